// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM output stage: channel state encoding
// and channel index constants.
package motor_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } ch_state_t;

    localparam int unsigned CH_R   = 0;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_B   = 2;
    localparam int unsigned NUM_CH = 3;

endpackage

// File: rtl/canal_motor.sv
// One motor channel: OFF/RAMP/RUN state machine, duty register with linear
// soft-start, and registered PWM compare against the shared counter.
module canal_motor
    import motor_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned DUTY_MAX = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                force_off,
    input  logic                ramp_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm,
    output logic                activo,
    output logic                en_rampa
);

    localparam int unsigned INC_W = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] DUTY_TOP = PWM_BITS'(DUTY_MAX);

    ch_state_t           state_q;
    ch_state_t           state_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                activo_d;
    logic                en_rampa_d;
    logic                stop_c;
    logic [INC_W-1:0]    duty_inc_c;
    logic                at_top_c;

    assign stop_c     = !req || force_off;
    assign duty_inc_c = {1'b0, duty_q} + INC_W'(1);
    assign at_top_c   = duty_inc_c >= INC_W'(DUTY_MAX);

    // State, duty and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_OFF;
            duty_q   <= '0;
            pwm      <= 1'b0;
            activo   <= 1'b0;
            en_rampa <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            pwm      <= (pwm_cnt < duty_q);
            activo   <= activo_d;
            en_rampa <= en_rampa_d;
        end
    end

    // Next state: a stop request or interlock always beats a ramp step
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (req && !force_off) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (stop_c)                     state_d = ST_OFF;
                else if (ramp_tick && at_top_c) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_c) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Duty and status next values
    always_comb begin
        duty_d     = duty_q;
        activo_d   = (state_d == ST_RUN);
        en_rampa_d = (state_d == ST_RAMP);
        if (state_d == ST_OFF) begin
            duty_d = '0;
        end else if (state_q == ST_RAMP && ramp_tick) begin
            duty_d = at_top_c ? DUTY_TOP : duty_inc_c[PWM_BITS-1:0];
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// Motor output stage: shared PWM and ramp timebases, one-motor-at-a-time
// interlock, and one soft-start PWM channel per colour pump.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned PWM_DIV    = 195,
    parameter int unsigned RAMP_TICKS = 500_000,
    parameter int unsigned DUTY_MAX   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] motores_req,
    output logic [2:0] pwm_out,
    output logic [2:0] motor_activo,
    output logic       ramping,
    output logic       fault
);

    localparam int unsigned PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned RAMP_W  = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    logic [PRESC_W-1:0]  presc_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [RAMP_W-1:0]   ramp_cnt_q;
    logic                presc_wrap_c;
    logic                ramp_tick_c;
    logic                multi_req_c;
    logic                force_off_c;
    logic [2:0]          en_rampa_w;

    assign presc_wrap_c = (presc_q == PRESC_W'(PWM_DIV - 1));
    assign ramp_tick_c  = (ramp_cnt_q == RAMP_W'(RAMP_TICKS - 1));
    assign multi_req_c  = ($countones(motores_req) > 1);
    // Offending request takes effect on the same edge that raises fault
    assign force_off_c  = fault || multi_req_c;

    // PWM and ramp timebases; the ramp counter is never restarted by requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            ramp_cnt_q <= '0;
        end else begin
            presc_q    <= presc_wrap_c ? '0 : presc_q + PRESC_W'(1);
            pwm_cnt_q  <= presc_wrap_c ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
            ramp_cnt_q <= ramp_tick_c ? '0 : ramp_cnt_q + RAMP_W'(1);
        end
    end

    // Interlock: sticky until an all-zero request vector is sampled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault <= 1'b0;
        end else if (multi_req_c) begin
            fault <= 1'b1;
        end else if (motores_req == 3'b000) begin
            fault <= 1'b0;
        end
    end

    canal_motor #(.PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX)) u_canal_r (
        .clk       (clk),
        .reset     (reset),
        .req       (motores_req[CH_R]),
        .force_off (force_off_c),
        .ramp_tick (ramp_tick_c),
        .pwm_cnt   (pwm_cnt_q),
        .pwm       (pwm_out[CH_R]),
        .activo    (motor_activo[CH_R]),
        .en_rampa  (en_rampa_w[CH_R])
    );

    canal_motor #(.PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX)) u_canal_g (
        .clk       (clk),
        .reset     (reset),
        .req       (motores_req[CH_G]),
        .force_off (force_off_c),
        .ramp_tick (ramp_tick_c),
        .pwm_cnt   (pwm_cnt_q),
        .pwm       (pwm_out[CH_G]),
        .activo    (motor_activo[CH_G]),
        .en_rampa  (en_rampa_w[CH_G])
    );

    canal_motor #(.PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX)) u_canal_b (
        .clk       (clk),
        .reset     (reset),
        .req       (motores_req[CH_B]),
        .force_off (force_off_c),
        .ramp_tick (ramp_tick_c),
        .pwm_cnt   (pwm_cnt_q),
        .pwm       (pwm_out[CH_B]),
        .activo    (motor_activo[CH_B]),
        .en_rampa  (en_rampa_w[CH_B])
    );

    assign ramping = |en_rampa_w;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios plus random request traffic,
// all checked against a cycle-level arithmetic model of the output stage.
module tb_motor_pwm_driver;

    localparam int unsigned PWM_BITS   = 3;
    localparam int unsigned PWM_DIV    = 1;
    localparam int unsigned RAMP_TICKS = 2;
    localparam int unsigned DUTY_MAX   = 7;
    localparam int unsigned PERIOD     = 1 << PWM_BITS;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_FULL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] motores_req = 3'b000;
    logic [2:0] pwm_out;
    logic [2:0] motor_activo;
    logic       ramping;
    logic       fault;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: edges since reset release, channel mode/duty, fault, pwm pins
    int       m_edges;
    int       m_mode [3];
    int       m_duty [3];
    bit       m_fault;
    bit [2:0] m_pwm;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PWM_BITS   (PWM_BITS),
        .PWM_DIV    (PWM_DIV),
        .RAMP_TICKS (RAMP_TICKS),
        .DUTY_MAX   (DUTY_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .motores_req  (motores_req),
        .pwm_out      (pwm_out),
        .motor_activo (motor_activo),
        .ramping      (ramping),
        .fault        (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_fault = 1'b0;
        m_pwm   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = M_IDLE;
            m_duty[i] = 0;
        end
    endtask

    // One clock edge with request vector r sampled
    task automatic model_edge(input logic [2:0] r);
        bit tick;
        int pcnt;
        bit multi;
        bit blocked;
        tick    = ((m_edges % RAMP_TICKS) == RAMP_TICKS - 1);
        pcnt    = (m_edges / PWM_DIV) % PERIOD;
        multi   = ($countones(r) > 1);
        blocked = m_fault || multi;
        for (int i = 0; i < 3; i++) begin
            m_pwm[i] = (pcnt < m_duty[i]);
            if (blocked || !r[i]) begin
                m_mode[i] = M_IDLE;
                m_duty[i] = 0;
            end else if (m_mode[i] == M_IDLE) begin
                m_mode[i] = M_RAMP;
            end else if (m_mode[i] == M_RAMP && tick) begin
                m_duty[i] = (m_duty[i] + 1 > DUTY_MAX) ? DUTY_MAX : m_duty[i] + 1;
                if (m_duty[i] >= DUTY_MAX) m_mode[i] = M_FULL;
            end
        end
        if (multi) m_fault = 1'b1;
        else if (r == 3'b000) m_fault = 1'b0;
        m_edges++;
    endtask

    task automatic check_outputs();
        logic [2:0] exp_act;
        logic       exp_ramp;
        exp_ramp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_act[i] = (m_mode[i] == M_FULL);
            if (m_mode[i] == M_RAMP) exp_ramp = 1'b1;
        end
        check("pwm_out", pwm_out, m_pwm);
        check("motor_activo", motor_activo, exp_act);
        check("ramping", ramping, exp_ramp);
        check("fault", fault, m_fault);
    endtask

    // Drive r across one posedge, then check at the following negedge
    task automatic step(input logic [2:0] r);
        motores_req = r;
        @(posedge clk);
        if (reset) model_edge(r);
        else model_reset();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pwm"}, pwm_out, 3'b000);
        check({tag, "_act"}, motor_activo, 3'b000);
        check({tag, "_ramp"}, ramping, 1'b0);
        check({tag, "_fault"}, fault, 1'b0);
    endtask

    // Request R until the model duty reaches target with a tick due next edge
    task automatic ramp_r_to(input int target, input bit need_tick, input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            if (m_duty[0] == target && m_mode[0] == M_RAMP &&
                (!need_tick || (m_edges % RAMP_TICKS) == RAMP_TICKS - 1)) found = 1'b1;
            else step(3'b001);
        end
        check({tag, "_reached"}, found, 1'b1);
    endtask

    initial begin
        int hi;
        bit done;
        model_reset();

        // Reset held with all requests high
        motores_req = 3'b111;
        #1;
        check_all_zero("rst_hold");
        for (int n = 0; n < 4; n++) step(3'b111);
        check_all_zero("rst_hold_end");

        // Release with no requests
        reset = 1'b1;
        for (int n = 0; n < 4; n++) step(3'b000);
        check_all_zero("idle");

        // Soft start on R up to RUN
        step(3'b001);
        check("ramp_start", ramping, 1'b1);
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            step(3'b001);
            if (m_mode[0] == M_FULL) done = 1'b1;
        end
        check("run_reached", done, 1'b1);
        check("run_activo", motor_activo, 3'b001);
        check("run_ramping", ramping, 1'b0);
        step(3'b001);
        hi = 0;
        for (int n = 0; n < int'(PERIOD); n++) begin
            step(3'b001);
            hi += int'(pwm_out[0]);
        end
        check("run_duty_hi", hi, DUTY_MAX);

        // Stop from RUN, then restart
        step(3'b000);
        step(3'b000);
        check("stop_pwm", pwm_out, 3'b000);
        check("stop_act", motor_activo, 3'b000);
        for (int n = 0; n < 6; n++) step(3'b001);

        // Interlock
        step(3'b011);
        check("intlk_fault", fault, 1'b1);
        step(3'b011);
        check("intlk_pwm", pwm_out, 3'b000);
        for (int n = 0; n < 3; n++) step(3'b001);
        check("intlk_sticky", fault, 1'b1);
        check("intlk_off", pwm_out | motor_activo, 3'b000);
        step(3'b000);
        check("intlk_clear", fault, 1'b0);
        step(3'b001);
        check("intlk_restart", ramping, 1'b1);

        // Async reset mid-ramp
        ramp_r_to(3, 1'b0, "mid_ramp");
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        step(3'b001);
        @(negedge clk);
        reset = 1'b1;
        step(3'b001);
        check("rst_restart", ramping, 1'b1);
        for (int n = 0; n < 4; n++) step(3'b001);

        // Stop coinciding with a ramp tick
        step(3'b000);
        ramp_r_to(4, 1'b1, "tick_drop");
        step(3'b000);
        check("tick_drop_ramp", ramping, 1'b0);
        step(3'b000);
        check("tick_drop_pwm", pwm_out, 3'b000);

        // Random request traffic with occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            int kind;
            int hold;
            logic [2:0] r;
            kind = int'($urandom_range(0, 19));
            hold = int'($urandom_range(1, 30));
            if (kind < 10)      r = 3'b001 << $urandom_range(0, 2);
            else if (kind < 14) r = 3'b000;
            else if (kind < 17) r = 3'($urandom);
            else if (kind < 19) r = 3'b111 & ~(3'b001 << $urandom_range(0, 2));
            else begin
                r = 3'b001 << $urandom_range(0, 2);
                reset = 1'b0;
                #1;
                check_all_zero("rand_rst");
                model_reset();
                step(r);
                @(negedge clk);
                reset = 1'b1;
            end
            for (int n = 0; n < hold; n++) step(r);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
